// File: rtl/bus_io_pkg.sv
// rtl/bus_io_pkg.sv - shared constants and types for the bus I/O responder
// Register byte offsets, FSM state type and the active-low 7-segment table.
package bus_io_pkg;

   localparam logic [31:0] OFF_LEDR   = 32'h00;
   localparam logic [31:0] OFF_HEX    = 32'h04;
   localparam logic [31:0] OFF_SW     = 32'h08;
   localparam logic [31:0] OFF_TIMER  = 32'h0C;
   localparam logic [31:0] OFF_CMP    = 32'h10;
   localparam logic [31:0] OFF_STATUS = 32'h14;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   // Segment order gfedcba, a lit segment is 0; entry k is the glyph for digit k.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - one hex digit to an active-low seven-segment pattern
module hex_to_7seg
   import bus_io_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/bus_io_responder.sv
// rtl/bus_io_responder.sv - AS_L/WE_L bus responder with wait states, board I/O and timer
// Accesses are latched at the strobe edge and commit on the edge that enters ACK.
module bus_io_responder
   import bus_io_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_BITS   = 5
)(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        AS_L,
   input  logic        WE_L,
   input  logic        IO_Select,
   input  logic [31:0] address,
   input  logic [31:0] data_out,
   output logic [31:0] data_in,
   output logic        DTACK_L,
   input  logic [9:0]  SW,
   output logic [9:0]  LEDR,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic        timer_irq
);

   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] WS_LAST = CW'(WAIT_STATES);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [CW-1:0]          r_wcnt;
   logic                   r_we;
   logic [ADDR_BITS-3:0]   r_off;
   logic [31:0]            r_wdata;
   logic [31:0]            r_data_in;
   logic [9:0]             r_ledr;
   logic [23:0]            r_hexval;
   logic [31:0]            r_timer;
   logic [31:0]            r_cmp;
   logic                   r_flag;
   logic [9:0]             r_sw_meta;
   logic [9:0]             r_sw_sync;

   logic                   w_commit;
   logic                   w_wr;
   logic                   w_rd;
   logic [ADDR_BITS-1:0]   w_off_byte;
   logic [31:0]            w_rdata;
   logic [6:0]             w_hex [6];
   logic                   w_unused;

   assign w_unused = ^{address[31:ADDR_BITS], address[1:0]};

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (!AS_L && IO_Select) w_next_state = WAIT;
         WAIT: begin
            if (AS_L || !IO_Select)    w_next_state = IDLE;
            else if (r_wcnt == WS_LAST) w_next_state = ACK;
         end
         ACK:  if (AS_L) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= IDLE;
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_off   <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next_state;
         r_wcnt  <= (r_state == WAIT && w_next_state == WAIT) ? r_wcnt + 1'b1 : '0;
         if (r_state == IDLE && w_next_state == WAIT) begin
            r_we    <= ~WE_L;
            r_off   <= address[ADDR_BITS-1:2];
            r_wdata <= data_out;
         end
      end
   end

   assign w_commit   = (r_state == WAIT) && (w_next_state == ACK);
   assign w_wr       = w_commit && r_we;
   assign w_rd       = w_commit && !r_we;
   assign w_off_byte = {r_off, 2'b00};

   always_comb begin
      w_rdata = '0;
      case (w_off_byte)
         OFF_LEDR[ADDR_BITS-1:0]:   w_rdata = {22'd0, r_ledr};
         OFF_HEX[ADDR_BITS-1:0]:    w_rdata = {8'd0, r_hexval};
         OFF_SW[ADDR_BITS-1:0]:     w_rdata = {22'd0, r_sw_sync};
         OFF_TIMER[ADDR_BITS-1:0]:  w_rdata = r_timer;
         OFF_CMP[ADDR_BITS-1:0]:    w_rdata = r_cmp;
         OFF_STATUS[ADDR_BITS-1:0]: w_rdata = {31'd0, r_flag};
         default:                   w_rdata = '0;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_data_in <= '0;
         r_ledr    <= '0;
         r_hexval  <= '0;
         r_cmp     <= 32'hFFFF_FFFF;
      end else begin
         if (w_rd) r_data_in <= w_rdata;
         if (w_wr && w_off_byte == OFF_LEDR[ADDR_BITS-1:0]) r_ledr   <= r_wdata[9:0];
         if (w_wr && w_off_byte == OFF_HEX[ADDR_BITS-1:0])  r_hexval <= r_wdata[23:0];
         if (w_wr && w_off_byte == OFF_CMP[ADDR_BITS-1:0])  r_cmp    <= r_wdata;
      end
   end

   // A compare hit in the same cycle as a write-1 clear keeps the flag set.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_timer <= '0;
         r_flag  <= 1'b0;
      end else begin
         if (w_wr && w_off_byte == OFF_TIMER[ADDR_BITS-1:0]) r_timer <= '0;
         else                                                r_timer <= r_timer + 32'd1;
         if (r_timer == r_cmp)
            r_flag <= 1'b1;
         else if (w_wr && w_off_byte == OFF_STATUS[ADDR_BITS-1:0] && r_wdata[0])
            r_flag <= 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= SW;
         r_sw_sync <= r_sw_meta;
      end
   end

   for (genvar k = 0; k < 6; k++) begin : g_hex
      hex_to_7seg u_hex (
         .i_nibble (r_hexval[4*k +: 4]),
         .o_seg    (w_hex[k])
      );
   end

   assign HEX0      = w_hex[0];
   assign HEX1      = w_hex[1];
   assign HEX2      = w_hex[2];
   assign HEX3      = w_hex[3];
   assign HEX4      = w_hex[4];
   assign HEX5      = w_hex[5];
   assign LEDR      = r_ledr;
   assign data_in   = r_data_in;
   assign DTACK_L   = (r_state != ACK);
   assign timer_irq = r_flag;

endmodule

// File: tb/tb_bus_io_responder.sv
// tb/tb_bus_io_responder.sv - randomized self-checking bench for bus_io_responder
module tb_bus_io_responder;

   localparam int WS = 2;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        AS_L = 1'b1;
   logic        WE_L = 1'b1;
   logic        IO_Select = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data_out = '0;
   logic [31:0] data_in;
   logic        DTACK_L;
   logic [9:0]  SW = '0;
   logic [9:0]  LEDR;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic        timer_irq;
   logic [6:0]  hex_o [6];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [9:0]  m_ledr;
   logic [23:0] m_hex;
   logic [9:0]  m_sw;
   logic [31:0] m_cmp;
   logic        m_flag;
   int          m_zero;
   logic [31:0] last_rd;

   bus_io_responder #(.WAIT_STATES(WS), .ADDR_BITS(5)) dut (
      .CLOCK_50 (CLOCK_50), .reset (reset), .AS_L (AS_L), .WE_L (WE_L),
      .IO_Select (IO_Select), .address (address), .data_out (data_out),
      .data_in (data_in), .DTACK_L (DTACK_L), .SW (SW), .LEDR (LEDR),
      .HEX0 (HEX0), .HEX1 (HEX1), .HEX2 (HEX2), .HEX3 (HEX3), .HEX4 (HEX4),
      .HEX5 (HEX5), .timer_irq (timer_irq)
   );

   assign hex_o[0] = HEX0;
   assign hex_o[1] = HEX1;
   assign hex_o[2] = HEX2;
   assign hex_o[3] = HEX3;
   assign hex_o[4] = HEX4;
   assign hex_o[5] = HEX5;

   always #10 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
      endcase
   endfunction

   // Timer value seen by an access committing at edge c: edges since it was last zeroed.
   function automatic logic [31:0] model_read(input logic [2:0] w, input int c);
      case (w)
         3'd0: model_read = {22'd0, m_ledr};
         3'd1: model_read = {8'd0, m_hex};
         3'd2: model_read = {22'd0, m_sw};
         3'd3: model_read = 32'(c - m_zero - 1);
         3'd4: model_read = m_cmp;
         3'd5: model_read = {31'd0, m_flag};
         default: model_read = '0;
      endcase
   endfunction

   task automatic model_reset();
      m_ledr = '0;
      m_hex  = '0;
      m_cmp  = 32'hFFFF_FFFF;
      m_flag = 1'b0;
      m_zero = cyc;
   endtask

   task automatic bus_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int commit);
      bit acked;
      int strobe;
      rd = '0;
      commit = -1;
      acked = 1'b0;
      @(negedge CLOCK_50);
      AS_L = 1'b0; IO_Select = 1'b1; WE_L = !we; address = addr; data_out = wd;
      strobe = cyc + 1;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(negedge CLOCK_50);
         if (DTACK_L === 1'b0) begin
            acked = 1'b1;
            commit = cyc;
            rd = data_in;
         end
      end
      AS_L = 1'b1; IO_Select = 1'b0; WE_L = 1'b1;
      check_eq("ack", {31'd0, acked}, 32'd1);
      if (acked) check_eq("latency", 32'(commit - strobe), 32'(WS + 1));
      @(negedge CLOCK_50);
      check_eq("dtack_release", {31'd0, DTACK_L}, 32'd1);
   endtask

   task automatic check_outputs();
      check_eq("ledr", {22'd0, LEDR}, {22'd0, m_ledr});
      for (int k = 0; k < 6; k++)
         check_eq($sformatf("hex%0d", k), {25'd0, hex_o[k]}, {25'd0, seg(m_hex[4*k +: 4])});
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      int c;
      bus_xfer(1'b1, addr, wd, rd, c);
      if (c >= 0) begin
         case (addr[4:2])
            3'd0: m_ledr = wd[9:0];
            3'd1: m_hex  = wd[23:0];
            3'd3: m_zero = c;
            3'd4: m_cmp  = wd;
            3'd5: if (wd[0]) m_flag = 1'b0;
            default: ;
         endcase
      end
      check_outputs();
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr);
      logic [31:0] rd, exp;
      int c;
      bus_xfer(1'b0, addr, $urandom, rd, c);
      exp = model_read(addr[4:2], c);
      if (c >= 0) begin
         check_eq(tag, rd, exp);
         check_eq({tag, "_hold"}, data_in, exp);
      end
      last_rd = rd;
   endtask

   task automatic aborted_write(input bit drop_select);
      int lows;
      lows = 0;
      @(negedge CLOCK_50);
      AS_L = 1'b0; IO_Select = 1'b1; WE_L = 1'b0; address = 32'h0; data_out = 32'h3FF;
      @(negedge CLOCK_50);
      if (drop_select) IO_Select = 1'b0;
      else             AS_L = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLOCK_50);
         if (DTACK_L !== 1'b1) lows++;
      end
      AS_L = 1'b1; IO_Select = 1'b0; WE_L = 1'b1;
      @(negedge CLOCK_50);
      check_eq("abort_no_ack", 32'(lows), 32'd0);
      check_eq("abort_ledr", {22'd0, LEDR}, {22'd0, m_ledr});
   endtask

   initial begin
      int offs[7] = '{0, 1, 2, 3, 4, 6, 7};
      logic [31:0] t1;
      logic [31:0] a;
      int o;

      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      model_reset();
      m_sw = '0;
      check_eq("rst_dtack", {31'd0, DTACK_L}, 32'd1);
      check_eq("rst_data_in", data_in, 32'd0);
      check_eq("rst_irq", {31'd0, timer_irq}, 32'd0);
      check_outputs();

      do_write(32'h0, 32'h2AB);
      check_eq("ledr_2ab", {22'd0, LEDR}, 32'h2AB);
      do_read("rd_ledr", 32'h0);

      do_write(32'h4, 32'h0012_3ABC);
      check_eq("hex0_c", {25'd0, HEX0}, {25'd0, 7'b1000110});
      check_eq("hex5_1", {25'd0, HEX5}, {25'd0, 7'b1111001});
      do_read("rd_hex", 32'h4);

      SW = 10'b0110101011;
      m_sw = SW;
      repeat (3) @(negedge CLOCK_50);
      do_read("rd_sw", 32'h8);
      check_eq("sw_1ab", last_rd, 32'h1AB);

      do_write(32'h10, 32'd20);
      do_write(32'h0C, 32'h0);
      repeat (25) @(negedge CLOCK_50);
      m_flag = 1'b1;
      check_eq("irq_set", {31'd0, timer_irq}, 32'd1);
      do_read("status_set", 32'h14);
      do_write(32'h14, 32'h0);
      do_read("status_w0", 32'h14);
      do_write(32'h14, 32'h1);
      do_read("status_clr", 32'h14);
      check_eq("irq_clr", {31'd0, timer_irq}, 32'd0);
      do_read("timer1", 32'h0C);
      t1 = last_rd;
      do_read("timer2", 32'h0C);
      check_eq("timer_nz", {31'd0, t1 != 0}, 32'd1);
      check_eq("timer_inc", {31'd0, last_rd > t1}, 32'd1);

      aborted_write(1'b0);
      aborted_write(1'b1);
      do_read("unmapped_1c", 32'h1C);

      for (int n = 0; n < 48; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            SW = 10'($urandom);
            m_sw = SW;
            repeat (3) @(negedge CLOCK_50);
         end
         o = offs[$urandom_range(0, 6)];
         a = $urandom;
         a[4:2] = 3'(o);
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
         else                           do_read($sformatf("rnd_rd_off%0h", o * 4), a);
      end

      do_write(32'h0, 32'h155);
      @(negedge CLOCK_50);
      AS_L = 1'b0; IO_Select = 1'b1; WE_L = 1'b0; address = 32'h0; data_out = 32'h0AA;
      @(negedge CLOCK_50);
      reset = 1'b1; AS_L = 1'b1; IO_Select = 1'b0; WE_L = 1'b1;
      @(negedge CLOCK_50);
      check_eq("rst_mid_dtack", {31'd0, DTACK_L}, 32'd1);
      check_eq("rst_mid_ledr", {22'd0, LEDR}, 32'd0);
      reset = 1'b0;
      model_reset();
      check_outputs();
      do_write(32'h0, 32'h0AA);
      do_read("post_rst_ledr", 32'h0);
      do_read("post_rst_cmp", 32'h10);
      do_read("post_rst_timer", 32'h0C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
